// File: rtl/lc3_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_fetch_pkg
// Description : Shared types and constants for the LC-3 fetch/prefetch unit.
//               fetch_state_t - fetch FSM states
//               fetch_entry_t - prefetch queue entry {instr, pc} (16-bit LC-3)
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_fetch_pkg;

    localparam logic [15:0] LC3_RESET_VECTOR = 16'h3000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } fetch_entry_t;

endpackage : lc3_fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO holding prefetched {instr, pc} entries.
//               Flush has priority over push and pop. Push and pop in the
//               same cycle leave the occupancy unchanged.
// Ports       : clk, rst (async, active-high)
//               i_push/i_push_data - write an entry (ignored when full)
//               i_pop              - drop the head (ignored when empty)
//               i_flush            - empty the queue
//               o_full/o_empty/o_count - occupancy status
//               o_head             - current head entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import lc3_fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  T                           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output T                           o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    T                   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : LC-3 fetch stage with prefetch queue. Owns the fetch PC,
//               issues single-outstanding reads over a req/gnt/rvalid
//               handshake, queues returned instructions tagged with their PC
//               and flushes/redirects on a taken branch.
// Ports       : clk, reset (async, active-high)
//               mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata - memory side
//               branch_taken/target_address                  - redirect
//               instr_valid/instr/instr_pc/instr_ready       - decode side
//               next_program_counter - instr_pc + 1 (wrapping)
//               queue_count          - queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
    import lc3_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LC3_RESET_VECTOR),
    parameter int              DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       branch_taken,
    input  logic [ADDR_W-1:0]          target_address,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    input  logic                       instr_ready,
    output logic [ADDR_W-1:0]          next_program_counter,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int               CNT_W   = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_req_addr;
    logic               r_discard;

    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  w_fetch_pc_nxt;
    logic [ADDR_W-1:0]  w_req_addr_nxt;
    logic               w_discard_nxt;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_post;

    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    entry_t             w_head;
    entry_t             w_push_data;

    assign w_push_data = '{instr: mem_rdata, pc: r_req_addr};
    // A branch flushes the queue, so a same-cycle pop has no effect.
    assign w_pop       = !w_empty && instr_ready && !branch_taken;

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_queue (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (branch_taken),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;
        w_discard_nxt  = r_discard;
        w_push         = 1'b0;
        w_count_post   = w_count;

        case (r_state)
            FETCH_IDLE: begin
                if (branch_taken) begin
                    // Queue is emptied this cycle, so the target can issue now.
                    w_fetch_pc_nxt = target_address;
                    w_req_addr_nxt = target_address;
                    w_state_nxt    = FETCH_REQ;
                end else if (!w_full) begin
                    w_req_addr_nxt = r_fetch_pc;
                    w_state_nxt    = FETCH_REQ;
                end
            end

            FETCH_REQ: begin
                // The request cannot be withdrawn; marking it stale early is
                // safe because responses are only consumed in FETCH_WAIT.
                if (branch_taken) begin
                    w_fetch_pc_nxt = target_address;
                    w_discard_nxt  = 1'b1;
                end
                if (mem_gnt) begin
                    w_state_nxt = FETCH_WAIT;
                    // Only a live request advances the PC; a stale one leaves
                    // the redirect target in place.
                    if (!branch_taken && !r_discard) begin
                        w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(1);
                    end
                end
            end

            FETCH_WAIT: begin
                if (mem_rvalid) begin
                    w_discard_nxt = 1'b0;
                    w_push        = !r_discard && !branch_taken;
                    w_count_post  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
                    if (branch_taken) begin
                        w_fetch_pc_nxt = target_address;
                        w_req_addr_nxt = target_address;
                        w_state_nxt    = FETCH_REQ;
                    end else if (w_count_post < C_DEPTH) begin
                        w_req_addr_nxt = r_fetch_pc;
                        w_state_nxt    = FETCH_REQ;
                    end else begin
                        w_state_nxt    = FETCH_IDLE;
                    end
                end else if (branch_taken) begin
                    w_fetch_pc_nxt = target_address;
                    w_discard_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = FETCH_IDLE;
            end
        endcase
    end

    assign mem_req              = (r_state == FETCH_REQ);
    assign mem_addr             = r_req_addr;
    assign instr_valid          = !w_empty;
    assign instr                = w_head.instr;
    assign instr_pc             = w_head.pc;
    assign next_program_counter = w_head.pc + ADDR_W'(1);
    assign queue_count          = w_count;

endmodule : fetch_prefetch_unit
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Directed self-checking bench for fetch_prefetch_unit.
//               u_dut0 uses the default reset PC; u_dut1 starts at FFFE to
//               exercise PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- DUT 0 (RESET_PC = 3000) ----------------
    logic        reset;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [15:0] mem_addr, mem_rdata;
    logic        branch_taken;
    logic [15:0] target_address;
    logic        instr_valid, instr_ready;
    logic [15:0] instr, instr_pc, npc;
    logic [2:0]  queue_count;

    fetch_prefetch_unit u_dut0 (
        .clk                  (clk),
        .reset                (reset),
        .mem_req              (mem_req),
        .mem_addr             (mem_addr),
        .mem_gnt              (mem_gnt),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .branch_taken         (branch_taken),
        .target_address       (target_address),
        .instr_valid          (instr_valid),
        .instr                (instr),
        .instr_pc             (instr_pc),
        .instr_ready          (instr_ready),
        .next_program_counter (npc),
        .queue_count          (queue_count)
    );

    // Memory model for DUT 0: rvalid arrives lat cycles after the grant cycle.
    int          lat   = 1;
    int          cnt   = 0;
    logic        pend  = 1'b0;
    logic [15:0] paddr = 16'h0;
    logic [15:0] gq[$];

    assign mem_rvalid = pend && (cnt == 0);
    assign mem_rdata  = 16'h1000 + {12'h000, paddr[3:0]};

    always @(posedge clk) begin
        if (mem_rvalid)
            pend <= 1'b0;
        else if (pend)
            cnt <= cnt - 1;
        if (mem_req && mem_gnt) begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            paddr <= mem_addr;
            gq.push_back(mem_addr);
        end
    end

    // ---------------- DUT 1 (RESET_PC = FFFE) ----------------
    logic        rst1;
    logic        req1, gnt1;
    logic        rv1 = 1'b0;
    logic [15:0] addr1;
    logic [15:0] rd1 = 16'h0;
    logic        br1;
    logic [15:0] tgt1;
    logic        valid1, ready1;
    logic [15:0] instr1, pc1, npc1;
    logic [2:0]  count1;
    logic [15:0] gq1[$];

    assign gnt1 = 1'b1;
    assign br1  = 1'b0;
    assign tgt1 = 16'h0;

    fetch_prefetch_unit #(
        .RESET_PC (16'hFFFE)
    ) u_dut1 (
        .clk                  (clk),
        .reset                (rst1),
        .mem_req              (req1),
        .mem_addr             (addr1),
        .mem_gnt              (gnt1),
        .mem_rvalid           (rv1),
        .mem_rdata            (rd1),
        .branch_taken         (br1),
        .target_address       (tgt1),
        .instr_valid          (valid1),
        .instr                (instr1),
        .instr_pc             (pc1),
        .instr_ready          (ready1),
        .next_program_counter (npc1),
        .queue_count          (count1)
    );

    always @(posedge clk) begin
        rv1 <= req1 && gnt1;
        rd1 <= 16'h1000 + {12'h000, addr1[3:0]};
        if (req1 && gnt1)
            gq1.push_back(addr1);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        rst1           = 1'b1;
        mem_gnt        = 1'b1;
        branch_taken   = 1'b0;
        target_address = 16'h0;
        instr_ready    = 1'b0;
        ready1         = 1'b0;
        lat            = 1;
        tick();
        tick();

        // Reset state
        chk("rst_mem_req",  32'(mem_req),     32'h0);
        chk("rst_valid",    32'(instr_valid), 32'h0);
        chk("rst_count",    32'(queue_count), 32'h0);
        chk("rst_instr",    32'(instr),       32'h0);
        chk("rst_instr_pc", 32'(instr_pc),    32'h0);
        chk("rst_mem_addr", 32'(mem_addr),    32'h0);

        // Test 1: fill the queue
        reset = 1'b0;
        tick();
        chk("t1_first_req",  32'(mem_req),  32'h1);
        chk("t1_first_addr", 32'(mem_addr), 32'h3000);
        repeat (8) tick();
        chk("t1_count_full", 32'(queue_count), 32'h4);
        chk("t1_req_idle",   32'(mem_req),     32'h0);
        repeat (3) tick();
        chk("t1_req_stays0", 32'(mem_req),     32'h0);
        chk("t1_n_grants",   32'(gq.size()),   32'h4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size())
                chk("t1_grant_addr", 32'(gq[i]), 32'h3000 + 32'(i));
        end
        chk("t1_head_pc",    32'(instr_pc), 32'h3000);
        chk("t1_head_instr", 32'(instr),    32'h1000);
        chk("t1_npc",        32'(npc),      32'h3001);

        // Test 2: single pop, then refill
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_head_pc",  32'(instr_pc),    32'h3001);
        chk("t2_npc",      32'(npc),         32'h3002);
        chk("t2_count",    32'(queue_count), 32'h3);
        tick();
        chk("t2_req",      32'(mem_req),     32'h1);
        chk("t2_addr",     32'(mem_addr),    32'h3004);
        repeat (2) tick();
        chk("t2_refill",   32'(queue_count), 32'h4);
        tick();

        // Test 3: branch while waiting for 3002, late stale response
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        repeat (4) tick();
        lat = 3;
        tick();
        chk("t3_pre_count", 32'(queue_count), 32'h2);
        branch_taken   = 1'b1;
        target_address = 16'h4000;
        tick();
        branch_taken = 1'b0;
        lat          = 1;
        chk("t3_flush_count", 32'(queue_count), 32'h0);
        chk("t3_flush_valid", 32'(instr_valid), 32'h0);
        tick();
        chk("t3_wait_count",  32'(queue_count), 32'h0);
        tick();
        chk("t3_stale_drop",  32'(queue_count), 32'h0);
        chk("t3_req",         32'(mem_req),     32'h1);
        chk("t3_addr",        32'(mem_addr),    32'h4000);
        repeat (2) tick();
        chk("t3_valid",       32'(instr_valid), 32'h1);
        chk("t3_head_pc",     32'(instr_pc),    32'h4000);
        chk("t3_head_instr",  32'(instr),       32'h1000);
        chk("t3_count",       32'(queue_count), 32'h1);

        // Test 4: branch with same-cycle rvalid and pop
        tick();
        branch_taken   = 1'b1;
        target_address = 16'h4100;
        instr_ready    = 1'b1;
        tick();
        branch_taken = 1'b0;
        instr_ready  = 1'b0;
        chk("t4_count",   32'(queue_count), 32'h0);
        chk("t4_valid",   32'(instr_valid), 32'h0);
        chk("t4_req",     32'(mem_req),     32'h1);
        chk("t4_addr",    32'(mem_addr),    32'h4100);
        repeat (2) tick();
        chk("t4_head_pc", 32'(instr_pc),    32'h4100);
        chk("t4_npc",     32'(npc),         32'h4101);
        chk("t4_count1",  32'(queue_count), 32'h1);

        // Test 6: reset while a read is outstanding
        lat = 3;
        tick();
        reset = 1'b1;
        #1;
        chk("t6_req_rst",   32'(mem_req),     32'h0);
        chk("t6_count_rst", 32'(queue_count), 32'h0);
        chk("t6_valid_rst", 32'(instr_valid), 32'h0);
        tick();
        reset = 1'b0;
        lat   = 1;
        tick();
        chk("t6_req",       32'(mem_req),     32'h1);
        chk("t6_addr",      32'(mem_addr),    32'h3000);
        tick();
        chk("t6_late_ign",  32'(queue_count), 32'h0);
        tick();
        chk("t6_head_pc",   32'(instr_pc),    32'h3000);
        chk("t6_head_instr",32'(instr),       32'h1000);
        chk("t6_count",     32'(queue_count), 32'h1);

        // Test 5: PC wrap on the FFFE instance
        rst1 = 1'b0;
        repeat (12) tick();
        chk("t5_n_grants", 32'(gq1.size()), 32'h4);
        if (gq1.size() >= 3) begin
            chk("t5_grant0", 32'(gq1[0]), 32'hFFFE);
            chk("t5_grant1", 32'(gq1[1]), 32'hFFFF);
            chk("t5_grant2", 32'(gq1[2]), 32'h0000);
        end
        chk("t5_count",      32'(count1), 32'h4);
        chk("t5_head_pc",    32'(pc1),    32'hFFFE);
        chk("t5_head_instr", 32'(instr1), 32'h100E);
        chk("t5_npc0",       32'(npc1),   32'hFFFF);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("t5_head_pc2",   32'(pc1),    32'hFFFF);
        chk("t5_head_instr2",32'(instr1), 32'h100F);
        chk("t5_npc_wrap",   32'(npc1),   32'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_fetch_prefetch_unit
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the single-register LC-3 fetch stage. It owns the fetch PC and issues instruction reads over a request/grant/response memory handshake, with at most one read outstanding. Returned instructions, each tagged with its PC, go into a DEPTH-entry prefetch queue. It sits between instruction memory and decode, and flushes and redirects on a taken branch.

Parameters:
ADDR_W, 16, address/PC width
DATA_W, 16, instruction width
RESET_PC, 16'h3000, PC value loaded on reset (ADDR_W bits)
DEPTH, 4, prefetch queue entries (>=2, power of two)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_req  out  1  read request valid
mem_addr  out  ADDR_W  read address; stable while mem_req=1 and mem_gnt=0
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid (>=1 cycle after grant)
mem_rdata  in  DATA_W  read data
branch_taken  in  1  redirect request, single-cycle pulse
target_address  in  ADDR_W  redirect PC
instr_valid  out  1  queue head valid
instr  out  DATA_W  queue head instruction
instr_pc  out  ADDR_W  PC of queue head
instr_ready  in  1  decode pops head when instr_valid=1
next_program_counter  out  ADDR_W  instr_pc + 1, wraps modulo 2^ADDR_W
queue_count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (async assert):
  - state=FETCH_IDLE, fetch_pc=RESET_PC.
  - Queue empty, discard flag=0.
  - Outputs: mem_req=0, instr_valid=0, queue_count=0; instr/instr_pc/mem_addr=0.
- FSM (state registered; mem_req = state==FETCH_REQ; mem_addr = req_addr register):
  - FETCH_IDLE: if count<DEPTH, req_addr<=fetch_pc and go FETCH_REQ.
  - FETCH_REQ: hold mem_req/mem_addr. On mem_gnt: fetch_pc<=fetch_pc+1 (wraps FFFF->0000), go FETCH_WAIT.
  - FETCH_WAIT: on mem_rvalid:
    - If discard=0, push {mem_rdata, req_addr}.
    - Then if post-update count<DEPTH, req_addr<=fetch_pc and go FETCH_REQ; else go FETCH_IDLE.
- Latency:
  - First mem_req 1 cycle after reset deasserts, with addr RESET_PC.
  - rvalid -> instr_valid: 1 cycle.
  - Back-to-back: the next request is asserted the cycle after rvalid.
- Queue: push and pop in the same cycle is allowed, with count unchanged. No pop when empty. A push is never attempted when full; the issue rule guarantees space.
- Branch (branch_taken=1) has priority over every other event:
  - Queue cleared next cycle (count=0, instr_valid=0); a same-cycle pop is ignored.
  - fetch_pc<=target_address.
  - In FETCH_IDLE: next request uses target_address.
  - In FETCH_WAIT without rvalid: discard<=1. With rvalid the same cycle: data dropped, then issue target.
  - In FETCH_REQ: request is held until granted (no withdrawal), then discard<=1.
  - discard clears on the dropped rvalid. Only one stale response is ever discarded.
  - Branch while discard=1: discard stays 1, fetch_pc updates.
- Reset mid-transaction abandons any outstanding read. A late rvalid arriving in FETCH_IDLE/FETCH_REQ is ignored.

Decomposition:
- Package lc3_fetch_pkg:
  - fetch_state_t enum {FETCH_IDLE, FETCH_REQ, FETCH_WAIT}
  - LC3_RESET_VECTOR=16'h3000
  - fetch_entry_t struct {instr, pc}
- One sub-module, fetch_queue: a synchronous FIFO with parameters DEPTH and entry type, ports push/pop/flush/full/empty/count, async active-high reset.

Test Plan:
1. Reset then mem_gnt=1 each cycle, rvalid 1 cycle after gnt, rdata=16'h1000+addr[3:0], instr_ready=0 -> requests to 3000,3001,3002,3003; queue_count reaches 4; mem_req stays 0 afterwards; instr_pc=3000, instr=1000.
2. From test 1, assert instr_ready for 1 cycle -> instr_pc=3001, next_program_counter=3002; the cycle after, new request to 3004.
3. branch_taken with target=16'h4000 while in FETCH_WAIT for 3002; rvalid arrives 2 cycles later -> that data is not queued; next mem_addr=4000; first instr_pc after the branch=4000; queue_count=0 the cycle after the branch.
4. branch_taken to 4100 in the same cycle as mem_rvalid and instr_ready -> no push, no pop effect; queue empties; next request 4100.
5. RESET_PC=16'hFFFE -> requests FFFE, FFFF, 0000; next_program_counter at head FFFF = 0000.
6. Assert reset while in FETCH_WAIT, rvalid arrives after deassertion -> ignored; first queued instr_pc=3000; mem_req=0 immediately on reset.
